// File: rtl/alu_arbiter_if.sv
// Bundle for alu_arbiter: two requester ports, shared-ALU port and response port.
// Optional RSP_ZERO signal exists only when ALU_ARBITER_ZERO_EN is defined.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [4:0]        req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [4:0]        req1_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
`ifdef ALU_ARBITER_ZERO_EN
  logic              rsp_zero;
`endif

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
`ifdef ALU_ARBITER_ZERO_EN
    output rsp_zero,
`endif
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
`ifdef ALU_ARBITER_ZERO_EN
    input  rsp_zero,
`endif
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one op in flight.
// Define ALU_ARBITER_ZERO_EN to add the registered RSP_ZERO result flag.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q;
  logic              last_q;
  logic              id_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [4:0]        op_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_valid_q;
`ifdef ALU_ARBITER_ZERO_EN
  logic              rsp_zero_q;
`endif

  logic any_valid;
  logic grant_id;
  logic handshake;

  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    // Contention goes to whoever was not granted last; otherwise the lone valid requester.
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = bus.req1_valid;
    end
    handshake = (state_q == StIdle) && any_valid;
  end

  always_comb begin
    bus.req0_ready = ~rst & handshake & ~grant_id;
    bus.req1_ready = ~rst & handshake & grant_id;
    if (state_q == StExec) begin
      bus.alu_a  = a_q;
      bus.alu_b  = b_q;
      bus.alu_op = op_q;
    end else begin
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.alu_op = 5'h00;
    end
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_id    = id_q;
    bus.rsp_data  = rsp_data_q;
`ifdef ALU_ARBITER_ZERO_EN
    bus.rsp_zero  = rsp_zero_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 5'h00;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ALU_ARBITER_ZERO_EN
      rsp_zero_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            last_q  <= grant_id;
            id_q    <= grant_id;
            a_q     <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q     <= grant_id ? bus.req1_b  : bus.req0_b;
            op_q    <= grant_id ? bus.req1_op : bus.req0_op;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_data_q  <= bus.alu_out;
          rsp_valid_q <= 1'b1;
`ifdef ALU_ARBITER_ZERO_EN
          rsp_zero_q  <= (bus.alu_out == '0);
`endif
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
// Provides the shared ALU; checks RSP_ZERO as well when ALU_ARBITER_ZERO_EN is defined.
module tb_alu_arbiter;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst;
  alu_arbiter_if #(.DATA_W(DATA_W)) bus ();

  alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      5'h01:   return a + b;
      5'h02:   return a - b;
      5'h03:   return a & b;
      5'h04:   return a | b;
      5'h05:   return a ^ b;
      5'h06:   return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  always_comb bus.alu_out = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: at most one transaction outstanding; age counts cycles since its grant.
  bit          busy;
  int          age;
  int          last_g;
  int          grants[$];
  logic        exp_id;
  logic [31:0] exp_a, exp_b, exp_data;
  logic [4:0]  exp_op;

  task automatic model_reset();
    busy   = 0;
    age    = 0;
    last_g = 1;
  endtask

  task automatic cycle(input bit v0, input logic [4:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input bit v1, input logic [4:0] op1,
                       input logic [31:0] a1, input logic [31:0] b1, input bit rr);
    int g;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = rr;
    #1;
    if (!busy) begin
      g = -1;
      if (v0 && v1) g = (last_g == 0) ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
      check("idle_ready0", 32'(bus.req0_ready), 32'(g == 0));
      check("idle_ready1", 32'(bus.req1_ready), 32'(g == 1));
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("idle_alu_op", 32'(bus.alu_op), 32'd0);
      check("idle_alu_a", bus.alu_a, 32'd0);
      if (g >= 0) begin
        busy     = 1;
        age      = 0;
        last_g   = g;
        grants.push_back(g);
        exp_id   = logic'(g);
        exp_a    = (g == 1) ? a1 : a0;
        exp_b    = (g == 1) ? b1 : b0;
        exp_op   = (g == 1) ? op1 : op0;
        exp_data = alu_fn(exp_op, exp_a, exp_b);
      end
    end else begin
      age++;
      check("busy_ready0", 32'(bus.req0_ready), 32'd0);
      check("busy_ready1", 32'(bus.req1_ready), 32'd0);
      if (age == 1) begin
        check("exec_alu_a", bus.alu_a, exp_a);
        check("exec_alu_b", bus.alu_b, exp_b);
        check("exec_alu_op", 32'(bus.alu_op), 32'(exp_op));
        check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end else begin
        check("resp_valid", 32'(bus.rsp_valid), 32'd1);
        check("resp_data", bus.rsp_data, exp_data);
        check("resp_id", 32'(bus.rsp_id), 32'(exp_id));
        check("resp_alu_b", bus.alu_b, 32'd0);
`ifdef ALU_ARBITER_ZERO_EN
        check("resp_zero", 32'(bus.rsp_zero), 32'(exp_data == 32'd0));
`endif
        if (rr) busy = 0;
      end
    end
  endtask

  task automatic idle_cycle(input bit rr);
    cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b0, 5'h0, 32'h0, 32'h0, rr);
  endtask

  // Assert rst between edges with both requesters valid; everything must read as reset.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    #1;
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0] ops [8];
    ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h1F};
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
    model_reset();
    pulse_reset();

    // ADD 5+7 from requester 0: ready at once, response two cycles later
    cycle(1'b1, 5'h01, 32'd5, 32'd7, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    check("add_ready0", 32'(bus.req0_ready), 32'd1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    check("add_data", bus.rsp_data, 32'd12);
    check("add_id", 32'(bus.rsp_id), 32'd0);

    // Contention from reset: grants alternate starting with requester 0
    pulse_reset();
    grants.delete();
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 5'h01, 32'd1, 32'd2, 1'b1, 5'h02, 32'd3, 32'd5, 1'b1);
    check("alt_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++) check("alt_grant", 32'(grants[i]), 32'(i % 2));
    // Last grant was requester 1 doing SUB 3-5; it ends up in RSP
    check("sub_data", exp_data, 32'hFFFF_FFFE);

    // Backpressure: response held for 4 cycles with both requesters valid
    cycle(1'b1, 5'h03, 32'hF0, 32'h3C, 1'b1, 5'h04, 32'h1, 32'h2, 1'b1);
    idle_cycle(1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'h05, 32'h7, 32'h1, 1'b1, 5'h05, 32'h9, 32'h1, 1'b0);
    cycle(1'b1, 5'h05, 32'h7, 32'h1, 1'b1, 5'h05, 32'h9, 32'h1, 1'b1);
    while (busy) idle_cycle(1'b1);

    // Signed overflow wraps; reserved opcode yields the ALU's zero
    cycle(1'b1, 5'h01, 32'h7FFF_FFFF, 32'd1, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    check("ovf_data", bus.rsp_data, 32'h8000_0000);
    cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1, 5'h1F, 32'h55, 32'hAA, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    check("rsvd_data", bus.rsp_data, 32'd0);
    check("rsvd_id", 32'(bus.rsp_id), 32'd1);

    // Zero-flag operands: XOR equal values, then AND non-zero
    cycle(1'b1, 5'h05, 32'h1234, 32'h1234, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    cycle(1'b1, 5'h03, 32'hF, 32'h1, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Reset in EXEC discards the op; requester 0 wins the next contention
    cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1, 5'h01, 32'd9, 32'd9, 1'b1);
    pulse_reset();
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    cycle(1'b1, 5'h01, 32'd4, 32'd4, 1'b1, 5'h02, 32'd4, 32'd1, 1'b1);
    check("post_rst_grant0", 32'(bus.req0_ready), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], $urandom(), $urandom(),
            1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], $urandom(), $urandom(),
            ($urandom_range(0, 3) != 0));
      if (i == 1500) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
